// File: rtl/drap_imem_loader.sv
// drap_imem_loader: packs a host byte stream big-endian into words and writes them to instruction memory at boot
module drap_imem_loader #(
  parameter int B = 32,
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] base_addr,
  input  logic [W:0]   word_count,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  output logic [W-1:0] mem_address,
  output logic [B-1:0] mem_data,
  output logic         mem_write,
  output logic         busy,
  output logic         cpu_hold,
  output logic         done
);
  localparam int NB = B / 8;
  localparam int CW = $clog2(NB) + 1;
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [W:0]    remaining;
  logic [B-9:0]  word;
  logic [B-1:0]  shifted;
  logic          last;
  assign shifted    = {word, byte_in};
  assign last       = cnt == CW'(NB - 1);
  assign byte_ready = state == COLLECT;
  assign mem_write  = state == WRITE;
  assign busy       = state != IDLE;
  assign cpu_hold   = busy;
  assign done       = state == DONE;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (word_count == '0 ? DONE : COLLECT) : IDLE;
      COLLECT: state_n = (byte_valid && last) ? WRITE : COLLECT;
      WRITE:   state_n = remaining == (W+1)'(1) ? DONE : COLLECT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      remaining   <= '0;
      word        <= '0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      if (state == IDLE && start) begin
        mem_address <= base_addr;
        remaining   <= word_count;
        cnt         <= '0;
      end
      if (state == COLLECT && byte_valid) begin
        word <= shifted[B-9:0];
        cnt  <= last ? '0 : cnt + CW'(1);
        if (last) mem_data <= shifted;
      end
      if (state == WRITE) begin
        mem_address <= mem_address + W'(1);
        remaining   <= remaining - (W+1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_drap_imem_loader.sv
// tb_drap_imem_loader: scoreboard bench for the instruction memory loader
module tb_drap_imem_loader;
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [6:0]  base_addr = '0;
  logic [7:0]  word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 0;
  logic        byte_ready, mem_write, busy, cpu_hold, done;
  logic [6:0]  mem_address;
  logic [31:0] mem_data;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  bit ready_seen = 0;
  logic [38:0] sb[$];
  logic [31:0] words[$];

  drap_imem_loader #(.B(32), .W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_address(mem_address), .mem_data(mem_data),
    .mem_write(mem_write), .busy(busy), .cpu_hold(cpu_hold), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (byte_ready) ready_seen = 1;
    if (mem_write) begin
      last_wr_cyc = cyc;
      if (sb.size() == 0) chk("spurious_write", {25'd0, mem_address, mem_data}, 64'd0);
      else chk("write", {25'd0, mem_address, mem_data}, {25'd0, sb.pop_front()});
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    byte_valid = 0;
    repeat (gap) @(negedge clk);
    byte_valid = 1;
    byte_in = b;
    while (!byte_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("ready_timeout", 0, 1);
    @(negedge clk);
    byte_valid = 0;
  endtask

  task automatic do_start(input logic [6:0] base, input logic [7:0] cnt);
    start = 1;
    base_addr = base;
    word_count = cnt;
    start_cyc = cyc;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done, 1);
    chk("busy_in_done", {busy, cpu_hold}, 2'b11);
    done_cyc = cyc;
    @(negedge clk);
    chk("done_width", done, 0);
    chk("busy_after", {busy, cpu_hold}, 2'b00);
  endtask

  task automatic run_load(input logic [6:0] base, input int gapmax);
    do_start(base, 8'(words.size()));
    foreach (words[i]) sb.push_back({7'(base + 7'(i)), words[i]});
    foreach (words[i])
      for (int j = 0; j < 4; j++)
        send_byte(words[i][31-8*j -: 8], gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
    wait_done();
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs", {byte_ready, mem_write, busy, cpu_hold, done, mem_address, mem_data}, 0);
    end
    // two words back to back
    words = '{32'h12345678, 32'h9ABCDEF0};
    run_load(7'h10, 0);
    chk("done_after_write", done_cyc - last_wr_cyc, 1);
    chk("addr_after", mem_address, 7'h12);
    chk("data_after", mem_data, 32'h9ABCDEF0);
    // zero-length load
    ready_seen = 0;
    words.delete();
    run_load(7'h33, 0);
    chk("zero_no_ready", ready_seen, 0);
    chk("zero_latency_ok", (done_cyc - start_cyc) <= 2, 1);
    // wrap at top of memory with host stalls
    words = '{32'h12345678, 32'h9ABCDEF0};
    run_load(7'h7F, 4);
    chk("wrap_addr_after", mem_address, 7'h01);
    // reset in the middle of the first word
    do_start(7'h20, 8'd2);
    for (int j = 0; j < 3; j++) send_byte(8'hA0 + 8'(j), 0);
    reset = 1;
    #1;
    chk("reset_mid", {busy, cpu_hold, mem_write, byte_ready}, 4'b0000);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    words = '{32'h11223344};
    run_load(7'h40, 1);
    chk("post_reset_addr", mem_address, 7'h41);
    // second start mid-load is ignored
    do_start(7'h50, 8'd2);
    sb.push_back({7'h50, 32'hCAFEF00D});
    sb.push_back({7'h51, 32'h0BADBEEF});
    send_byte(8'hCA, 0);
    send_byte(8'hFE, 0);
    do_start(7'h00, 8'd5);
    send_byte(8'hF0, 0);
    send_byte(8'h0D, 0);
    send_byte(8'h0B, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    wait_done();
    repeat (5) @(negedge clk);
    chk("restart_ignored", {busy, mem_address}, {1'b0, 7'h52});
    chk("sb_empty2", sb.size(), 0);
    // full-depth load wraps through every location
    words.delete();
    for (int i = 0; i < 128; i++) words.push_back({8'(i), ~8'(i), 8'(i * 3), 8'h5A});
    run_load(7'h05, 0);
    chk("full_addr_after", mem_address, 7'h05);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
